// File: rtl/wr_cell_pkg.sv
// Shared LDPC address-cell definitions: cycle encoding and packed-offset field slicing.
package wr_cell_pkg;

  localparam logic [1:0] CYC_ZERO = 2'b00;
  localparam logic [1:0] CYC_1    = 2'b01;
  localparam logic [1:0] CYC_2    = 2'b10;
  localparam logic [1:0] CYC_3    = 2'b11;

  // Zero-offset cycles take no field from the packed offsets at all.
  function automatic logic cyc_has_off(input logic [1:0] cyc);
    return cyc != CYC_ZERO;
  endfunction

  // LSB of the offset field for a cycle; fields are packed {off1, off2, off3}.
  function automatic int unsigned fld_lsb(input logic [1:0] cyc, input int unsigned a_wid);
    int unsigned lsb;
    case (cyc)
      CYC_1:   lsb = 2 * a_wid;
      CYC_2:   lsb = a_wid;
      default: lsb = 0;
    endcase
    return lsb;
  endfunction

  function automatic logic cyc_is_last(input logic [1:0] cyc);
    return cyc == CYC_3;
  endfunction

endpackage

// File: rtl/wr_cell_if.sv
// Request and write-issue signals of the LDPC write-address cell.
interface wr_cell_if #(
  parameter int A_WID = 8,
  parameter int P_WID = 4
);
  logic               en;
  logic [1:0]         cycle;
  logic [A_WID-1:0]   base_addr;
  logic [3*A_WID-1:0] addr_offset;
  logic               flush;
  logic               wr_en;
  logic [A_WID-1:0]   wr_addr;
  logic               wr_last;
  logic [P_WID-1:0]   pending;

  modport master (
    output en, cycle, base_addr, addr_offset, flush,
    input  wr_en, wr_addr, wr_last, pending
  );

  modport slave (
    input  en, cycle, base_addr, addr_offset, flush,
    output wr_en, wr_addr, wr_last, pending
  );
endinterface

// File: rtl/wr_cell_vld_dly_line.sv
// Valid-qualified fixed-depth shift register; valids reset/clear, payload is free-running.
module vld_dly_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic             nxt_vld
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_data = data_p[DEPTH-1];

  // nxt_vld flags the entry that reaches the final stage at the coming edge.
  generate
    if (DEPTH == 1) begin : g_single
      assign nxt_vld = in_vld & ~clr;
    end else begin : g_multi
      assign nxt_vld = vld_p[DEPTH-2] & ~clr;
    end
  endgenerate

endmodule

// File: rtl/wr_cell.sv
// LDPC message-memory write-address cell: replays read-side addresses LAT cycles later as writes.
module wr_cell
  import wr_cell_pkg::*;
#(
  parameter int A_WID = 8,
  parameter int LAT   = 4,
  parameter int P_WID = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  wr_cell_if.slave bus
);

  logic               vld_p0;
  logic [A_WID-1:0]   off_p0;
  logic [A_WID-1:0]   addr_p0;
  logic               last_p0;
  logic               out_vld;
  logic [A_WID:0]     out_data;
  logic               nxt_vld;
  logic [P_WID-1:0]   pending_q;

  // Stage p0: offset select and address sum, masked when idle so X never enters the line.
  always_comb begin
    off_p0  = '0;
    addr_p0 = '0;
    last_p0 = 1'b0;
    if (bus.en) begin
      if (cyc_has_off(bus.cycle))
        off_p0 = bus.addr_offset[fld_lsb(bus.cycle, A_WID) +: A_WID];
      addr_p0 = bus.base_addr + off_p0;
      last_p0 = cyc_is_last(bus.cycle);
    end
  end

  assign vld_p0 = bus.en & ~bus.flush;

  // Stages p1..pLAT: the final stage doubles as the write-issue register.
  vld_dly_line #(
    .WIDTH (A_WID + 1),
    .DEPTH (LAT)
  ) u_dly (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bus.flush),
    .in_vld   (vld_p0),
    .in_data  ({last_p0, addr_p0}),
    .out_vld  (out_vld),
    .out_data (out_data),
    .nxt_vld  (nxt_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else if (bus.flush) begin
      pending_q <= '0;
    end else begin
      case ({vld_p0, nxt_vld})
        2'b10:   pending_q <= pending_q + P_WID'(1);
        2'b01:   pending_q <= pending_q - P_WID'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

  assign bus.wr_en   = out_vld;
  assign bus.wr_addr = out_vld ? out_data[A_WID-1:0] : '0;
  assign bus.wr_last = out_vld & out_data[A_WID];
  assign bus.pending = pending_q;

endmodule

// File: doc/wr_cell.md
Name: wr_cell

Overview:
- Write-side address generator for the LDPC message memory; the counterpart of the read-address cell.
- Accepts the same per-cycle address request as the read side: en, a 2-bit cycle index, a base address and three packed offsets.
- Forms the target address and delays it by the processing-unit latency LAT, then presents it as a write strobe with address.
- Updated messages are thus written back to exactly the locations they were read from.

Parameters:
A_WID, 8, address width in bits.
LAT, 4, cycles from request acceptance to write issue; legal range 1..15.
P_WID, 4, width of the pending counter; must satisfy 2^P_WID > LAT.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  reset; asynchronous, active-low.
en  input  1  request valid this cycle.
cycle  input  2  offset select: 01 = high field, 10 = middle field, 11 = low field, 00 = zero offset.
base_addr  input  A_WID  row base address.
addr_offset  input  3*A_WID  packed offsets {off1, off2, off3}, off1 in the MSBs.
flush  input  1  synchronous discard of all in-flight requests.
wr_en  output  1  write strobe to message memory.
wr_addr  output  A_WID  write address; 0 whenever wr_en = 0.
wr_last  output  1  high with a write whose originating cycle was 11 (end of 3-cycle group).
pending  output  P_WID  number of accepted requests not yet issued.

Behaviour:
- Reset (async): all stage valids cleared; wr_en = 0, wr_addr = 0, wr_last = 0, pending = 0.
- Address select (combinational, same cycle as en):
  - cycle 01 -> addr_offset[3A-1:2A]
  - cycle 10 -> [2A-1:A]
  - cycle 11 -> [A-1:0]
  - cycle 00 -> 0
- Address sum: base_addr + selected offset, truncated to A_WID bits (wraps modulo 2^A_WID, no saturation).
- Delay line: LAT stages, each holding {valid, addr, last}; last = (cycle == 11).
  - Stage 1 loads at the posedge where en = 1; all stages shift every clock, no stall.
  - The output registers take stage LAT.
- Latency:
  - Request sampled with en = 1 at edge N -> wr_en = 1 with matching wr_addr/wr_last during the cycle after edge N+LAT-1, i.e. exactly LAT cycles later.
  - Back-to-back requests produce back-to-back writes in the same order; throughput 1 per cycle.
- Bubbles: en = 0 inserts an invalid slot. An invalid slot at the output drives wr_en = 0, wr_addr = 0, wr_last = 0.
- pending update each edge:
  - +1 if a request is accepted.
  - -1 if stage LAT holds a valid entry, i.e. the write issued next cycle.
  - Both or neither -> unchanged.
  - Never exceeds LAT.
- flush = 1 at an edge:
  - Clears every stage valid and sets pending = 0.
  - Output registers go to wr_en = 0, wr_addr = 0, wr_last = 0 from the next cycle.
  - flush and en in the same cycle: flush wins and the request is dropped.
  - A write already being presented in the flush cycle still completes that cycle.
- Reset mid-operation: all in-flight entries are lost immediately; no write is issued after reset deasserts until new requests age LAT cycles.
- X on base_addr/addr_offset while en = 0 must not propagate to wr_addr.

Decomposition:
- Shared ldpc package holds:
  - Cycle encoding constants CYC_ZERO = 2'b00, CYC_1 = 2'b01, CYC_2 = 2'b10, CYC_3 = 2'b11, used by both read and write cells.
  - The packed-offset field slicing helpers.
- One sub-module, vld_dly_line: parameterised width and depth; valid-qualified shift register with async reset and sync clear, reusable for data-path alignment.
- The offset mux, adder and pending counter stay in wr_cell.

Test Plan:
- Single write:
  - Stimulus: LAT = 4; at edge 0 drive en = 1, cycle = 01, base = 8'h10, offsets = {8'h05, 8'h20, 8'h33}.
  - Response: wr_en = 1 with wr_addr = 8'h15 and wr_last = 0 exactly 4 cycles later, for one cycle only; pending 1 -> 0.
- Three-cycle group:
  - Stimulus: cycles 01, 10, 11 back-to-back with the same inputs.
  - Response: writes 8'h15, 8'h30, 8'h43 on consecutive cycles; wr_last = 1 only with 8'h43; pending peaks at 3.
- Wrap and zero offset:
  - Stimulus: base = 8'hF0, cycle = 11, low offset = 8'h20; then cycle = 00.
  - Response: wr_addr = 8'h10, then wr_addr = 8'hF0.
- Bubbles:
  - Stimulus: en pattern 1, 0, 1.
  - Response: write, idle cycle with wr_addr = 0, write; spacing preserved.
- Flush:
  - Stimulus: 3 requests in flight, then flush asserted together with en.
  - Response: no further writes, the concurrent request is dropped, pending = 0 the next cycle.
- Async reset mid-stream:
  - Stimulus: assert reset_n low while 2 requests are in flight.
  - Response: all outputs 0 immediately; no write appears after release.
